// File: rtl/if_prefetch_queue_pkg.sv
// Shared fetch-side definitions: state encodings, PC step, bus widths and a
// saturating adder used by the optional performance counters.
package if_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    localparam int IF_XLEN         = 32;
    localparam int INST_BUS_W      = IF_XLEN;
    localparam int INST_ADDR_BUS_W = IF_XLEN;
    localparam int PC_INC          = 4;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// DEPTH-entry synchronous FIFO with flush, occupancy count and a registered
// head that reads as zero whenever the FIFO is empty.
module if_inst_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic                        head_valid,
    output logic [W-1:0]                head_data,
    output logic [occ_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [W-1:0]     head_q, head_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0) && !flush;
    assign do_push = push && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_q == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem_q[i] <= push_data;
        end
    end

    // The head is precomputed for the next cycle; when the next head is the
    // entry being written right now it has to bypass the storage array.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (count_d == '0)
                head_d = '0;
            else if (do_push && (rd_ptr_d == wr_ptr_q))
                head_d = push_data;
            else
                head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_q;
    assign count      = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one fetch at a time and
// buffers responses; redirects flush. IF_PERF_CNT_EN adds performance counters.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int               XLEN     = INST_BUS_W,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    mem_req,
    output logic [XLEN-1:0]         mem_addr,
    input  logic                    mem_grant,
    input  logic                    memcnf,
    input  logic                    mem_rsp_valid,
    input  logic [XLEN-1:0]         mem_rsp_inst,
    input  logic [XLEN-1:0]         mem_rsp_addr,
    output logic                    out_valid,
    output logic [XLEN-1:0]         out_inst,
    output logic [XLEN-1:0]         out_pc,
    input  logic                    out_ready,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_dropped,
    output logic [31:0]             perf_empty_cycles,
`endif
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    typedef logic [XLEN-1:0] inst_bus_t;
    typedef logic [XLEN-1:0] inst_addr_bus_t;

    if_state_e      state_q, state_d;
    inst_addr_bus_t fetch_pc_q, fetch_pc_d;
    logic           fire, push, head_valid;
    logic [2*XLEN-1:0] head;

    // One request in flight at most, and only with a free slot, so the FIFO
    // can never be pushed while full.
    assign mem_req  = rst && (state_q == IF_IDLE) && !memcnf &&
                      (occupancy < OCC_W'(DEPTH)) && !redirect_valid;
    assign mem_addr = fetch_pc_q;
    assign fire     = mem_req && mem_grant;
    assign push     = (state_q == IF_WAIT) && mem_rsp_valid && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if (state_q == IF_WAIT) state_d = mem_rsp_valid ? IF_IDLE : IF_DROP;
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (fire) begin
                        state_d    = IF_WAIT;
                        fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
                    end
                end
                IF_WAIT, IF_DROP: begin
                    if (mem_rsp_valid) state_d = IF_IDLE;
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    if_inst_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({inst_bus_t'(mem_rsp_inst), inst_addr_bus_t'(mem_rsp_addr)}),
        .pop        (head_valid && out_ready),
        .head_valid (head_valid),
        .head_data  (head),
        .count      (occupancy)
    );

    assign out_valid = head_valid;
    assign out_inst  = head[2*XLEN-1:XLEN];
    assign out_pc    = head[XLEN-1:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [31:0] perf_empty_q, perf_empty_d;
    logic [31:0] drop_inc;

    // A redirect throws away every held entry plus a response landing with it.
    always_comb begin
        drop_inc = '0;
        if (redirect_valid)
            drop_inc = 32'(occupancy) + ((state_q == IF_WAIT && mem_rsp_valid) ? 32'd1 : 32'd0);
        else if (state_q == IF_DROP && mem_rsp_valid)
            drop_inc = 32'd1;
        perf_fetched_d = sat_add32(perf_fetched_q, push ? 32'd1 : 32'd0);
        perf_dropped_d = sat_add32(perf_dropped_q, drop_inc);
        perf_empty_d   = sat_add32(perf_empty_q, head_valid ? 32'd0 : 32'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_empty_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
            perf_empty_q   <= perf_empty_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_dropped      = perf_dropped_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

    logic           prev_stall_q;
    inst_addr_bus_t prev_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_stall_q <= 1'b0;
            prev_addr_q  <= RESET_PC;
        end else begin
            prev_stall_q <= mem_req && !mem_grant;
            prev_addr_q  <= mem_addr;
            if (state_q == IF_IDLE && mem_rsp_valid)
                $error("if_prefetch_queue: response received while no fetch is outstanding");
            if (state_q == IF_WAIT && mem_rsp_valid && mem_rsp_addr != fetch_pc_q - XLEN'(PC_INC))
                $error("if_prefetch_queue: response address %h does not match request", mem_rsp_addr);
            if (prev_stall_q && mem_addr != prev_addr_q)
                $error("if_prefetch_queue: mem_addr changed while request pending");
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised and directed bench for if_prefetch_queue against a queue-based
// reference model of the fetch/flush rules and a latency-modelled memory.
module tb_if_prefetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant = 1'b0;
    logic        memcnf = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_inst = '0;
    logic [31:0] mem_rsp_addr = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped, perf_empty_cycles;
`endif

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_grant      (mem_grant),
        .memcnf         (memcnf),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_inst   (mem_rsp_inst),
        .mem_rsp_addr   (mem_rsp_addr),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
`ifdef IF_PERF_CNT_EN
        .perf_fetched      (perf_fetched),
        .perf_dropped      (perf_dropped),
        .perf_empty_cycles (perf_empty_cycles),
`endif
        .occupancy      (occupancy)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    // Reference state: queue contents, next fetch address, outstanding fetch.
    ent_t        mq[$];
    logic [31:0] mpc;
    logic        pend, stale;
    logic [31:0] pend_addr;
    int          pend_cnt;

    logic        k_redirect, k_memcnf, k_ready, k_grant;
    logic [31:0] k_rpc;
    int          lat;

    logic [31:0] obs_grants[$];
    logic [31:0] obs_pops[$];
    logic        obs_req;
    logic [31:0] obs_addr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < obs_pops.size()) ? obs_pops[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] grant_at(input int i);
        return (i < obs_grants.size()) ? obs_grants[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_obs();
        obs_grants.delete();
        obs_pops.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        mem_grant = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        mq.delete();
        mpc = RESET_PC;
        pend = 1'b0;
        stale = 1'b0;
        pend_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance it.
    task automatic step();
        logic rsp, r, pop, req;
        logic [31:0] pc_before;
        ent_t e;
        @(negedge clk);
        rsp = pend && (pend_cnt == 0);
        r   = k_redirect && !(stale && rsp);
        mem_rsp_valid  = rsp;
        mem_rsp_addr   = rsp ? pend_addr : 32'd0;
        mem_rsp_inst   = rsp ? inst_of(pend_addr) : 32'd0;
        redirect_valid = r;
        redirect_pc    = k_rpc;
        memcnf         = k_memcnf;
        out_ready      = k_ready;
        mem_grant      = k_grant;
        #1;
        req = !pend && !k_memcnf && (mq.size() < DEPTH) && !r;
        pop = (mq.size() != 0) && k_ready;
        check("mem_req", 32'(mem_req), 32'(req));
        check("mem_addr", mem_addr, mpc);
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'd0);
        check("out_inst", out_inst, (mq.size() != 0) ? mq[0].inst : 32'd0);
        obs_req  = mem_req;
        obs_addr = mem_addr;
        if (mem_req && k_grant) obs_grants.push_back(mem_addr);
        if (out_valid && k_ready && !r) obs_pops.push_back(out_pc);
        @(posedge clk);
        pc_before = mpc;
        if (r) begin
            mq.delete();
            mpc = k_rpc;
            if (pend && !rsp) stale = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (rsp && !stale) begin
                e.inst = inst_of(pend_addr);
                e.pc   = pend_addr;
                mq.push_back(e);
            end
            if (rsp) stale = 1'b0;
            if (req && k_grant) mpc = mpc + 32'd4;
        end
        if (rsp) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (req && k_grant) begin
            pend      = 1'b1;
            pend_addr = pc_before;
            pend_cnt  = lat - 1;
        end
    endtask

    initial begin
        k_redirect = 1'b0; k_memcnf = 1'b0; k_ready = 1'b1; k_grant = 1'b1;
        k_rpc = 32'd0; lat = 1;

        // Straight-line fetch from RESET_PC.
        do_reset();
        clear_obs();
        repeat (14) step();
        check("a_first_addr", grant_at(0), 32'h100);
        check("a_pop0", pop_at(0), 32'h100);
        check("a_pop1", pop_at(1), 32'h104);
        check("a_pop2", pop_at(2), 32'h108);

        // Back-pressure fills the queue, then drains in order.
        do_reset();
        k_ready = 1'b0;
        clear_obs();
        repeat (20) step();
        check("b_grants", 32'(obs_grants.size()), 32'd4);
        check("b_occ", 32'(occupancy), 32'd4);
        check("b_req_idle", 32'(obs_req), 32'd0);
        k_ready = 1'b1;
        clear_obs();
        repeat (12) step();
        check("b_pop0", pop_at(0), 32'h100);
        check("b_pop1", pop_at(1), 32'h104);
        check("b_pop2", pop_at(2), 32'h108);
        check("b_pop3", pop_at(3), 32'h10C);
        check("b_resume", grant_at(0), 32'h110);

        // Redirect while waiting on 0x108; its response comes two cycles later.
        do_reset();
        k_ready = 1'b1; lat = 3;
        clear_obs();
        for (int n = 0; n < 100 && obs_grants.size() < 3; n++) step();
        check("c_third_grant", grant_at(2), 32'h108);
        k_redirect = 1'b1; k_rpc = 32'h400;
        step();
        k_redirect = 1'b0;
        #1 check("c_flush_occ", 32'(occupancy), 32'd0);
        clear_obs();
        repeat (20) step();
        check("c_next_addr", grant_at(0), 32'h400);
        check("c_first_pop", pop_at(0), 32'h400);

        // Redirect coinciding with a response and a dequeue.
        do_reset();
        k_ready = 1'b0; lat = 2;
        for (int n = 0; n < 100 && !(mq.size() >= 1 && pend && pend_cnt == 0 && !stale); n++) step();
        check("d_setup_occ", 32'(occupancy), 32'(mq.size()));
        k_redirect = 1'b1; k_rpc = 32'h400; k_ready = 1'b1;
        clear_obs();
        step();
        k_redirect = 1'b0;
        #1 check("d_flush_occ", 32'(occupancy), 32'd0);
        check("d_flush_valid", 32'(out_valid), 32'd0);
        check("d_void_pop", 32'(obs_pops.size()), 32'd0);
        clear_obs();
        repeat (15) step();
        check("d_next_addr", grant_at(0), 32'h400);
        check("d_first_pop", pop_at(0), 32'h400);

        // memcnf holds off requests; release issues in the same cycle.
        do_reset();
        k_ready = 1'b1; lat = 1; k_memcnf = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check("e_req_blocked", 32'(obs_req), 32'd0);
            check("e_addr_stable", obs_addr, 32'h100);
        end
        k_memcnf = 1'b0;
        step();
        check("e_req_release", 32'(obs_req), 32'd1);

        // Address wrap at the top of the space.
        do_reset();
        k_redirect = 1'b1; k_rpc = 32'hFFFF_FFFC;
        step();
        k_redirect = 1'b0;
        clear_obs();
        repeat (10) step();
        check("f_wrap_first", grant_at(0), 32'hFFFF_FFFC);
        check("f_wrap_next", grant_at(1), 32'h0000_0000);
        check("f_wrap_pop", pop_at(1), 32'h0000_0000);

        // Reset asserted mid-WAIT with a non-empty queue (checks inside do_reset).
        k_ready = 1'b0; lat = 3;
        for (int n = 0; n < 100 && !(mq.size() >= 2 && pend); n++) step();
        check("f_pre_rst_occ", 32'(occupancy), 32'd2);
        do_reset();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            k_redirect = ($urandom_range(0, 99) < 3);
            k_rpc      = $urandom() & 32'hFFFF_FFFC;
            k_memcnf   = ($urandom_range(0, 99) < 20);
            k_ready    = ($urandom_range(0, 99) < 60);
            k_grant    = ($urandom_range(0, 99) < 70);
            lat        = int'($urandom_range(1, 4));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised successor to the single-slot IF stage: owns the fetch PC, issues sequential fetches to memcontrol and buffers returned instructions in a DEPTH-entry FIFO.
- Sits between memcontrol and IF/ID; replaces the pc_reg/IF pair on the fetch side.
- Branch redirects flush the queue and discard in-flight stale responses, so no instruction is lost or duplicated.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 4, instruction queue entries; power of two, 2..16.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch interception; flush and refetch.
- redirect_pc  in  XLEN  new fetch address.
- mem_req  out  1  fetch request to memcontrol.
- mem_addr  out  XLEN  fetch address; held stable while mem_req is high and not granted.
- mem_grant  in  1  memcontrol accepted the request this cycle.
- memcnf  in  1  memcontrol busy with data port; suppresses mem_req.
- mem_rsp_valid  in  1  instruction returned.
- mem_rsp_inst  in  XLEN  returned instruction.
- mem_rsp_addr  in  XLEN  address of the returned instruction.
- out_valid  out  1  queue head valid.
- out_inst  out  XLEN  head instruction.
- out_pc  out  XLEN  head address.
- out_ready  in  1  IF/ID accepts the head (not stalled).
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset (rst low, asynchronous): fetch_pc=RESET_PC, queue empty, state IDLE; mem_req=0, mem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, occupancy=0.
- State IDLE:
  - mem_req = !memcnf && (occupancy + 0 < DEPTH) && !redirect_valid; mem_addr=fetch_pc.
  - On mem_req && mem_grant: go to WAIT; fetch_pc += 4, wrapping modulo 2^XLEN.
  - Credit rule: at most one request in flight, and it is issued only when a free slot is guaranteed, so enqueue never hits a full queue.
- State WAIT:
  - mem_req=0.
  - On mem_rsp_valid: enqueue {mem_rsp_inst, mem_rsp_addr}, go to IDLE.
  - The next request may issue no earlier than the following cycle (one-cycle bubble per fetch).
- State DROP:
  - mem_req=0; the next mem_rsp_valid is discarded and the state returns to IDLE.
- Redirect, which has the highest priority in every state:
  - Queue cleared (occupancy=0 next cycle) and fetch_pc=redirect_pc.
  - Any dequeue in the same cycle is void; IF/ID is flushed by the same branch.
  - WAIT with no response this cycle -> DROP.
  - WAIT with a response in the same cycle -> the response is discarded, state goes to IDLE.
  - IDLE with a grant in the same cycle cannot occur, because mem_req is masked by redirect_valid.
  - DROP stays DROP. Redirect while in DROP overwrites fetch_pc only.
  - First request to redirect_pc is issued the cycle after the redirect at the earliest.
- Output side:
  - out_valid = occupancy!=0; head fields are driven from the registered FIFO.
  - Dequeue on out_valid && out_ready.
  - Enqueue and dequeue in the same cycle: occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - out_inst and out_pc are 0 when the queue is empty.
- Protocol checks (simulation only, `$error`):
  - mem_rsp_valid in IDLE.
  - mem_rsp_addr != fetch_pc-4 in WAIT.
  - mem_addr change while mem_req && !mem_grant.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds outputs perf_fetched (32-bit, +1 per enqueue), perf_dropped (32-bit, +1 per discarded response or flushed entry, adding the flushed count) and perf_empty_cycles (32-bit, +1 per cycle with out_valid=0).
  - All counters reset to 0 and saturate at all-ones.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines file (defines.v style):
  - fetch state encodings IF_IDLE=2'd0, IF_WAIT=2'd1, IF_DROP=2'd2;
  - PC increment constant 4;
  - `InstBus`/`InstAddrBus` widths tied to XLEN.
- One sub-module: if_inst_fifo, a DEPTH-parametrised synchronous FIFO with flush, count, push/pop and registered head.

Test Plan:
- Reset with RESET_PC=0x100, out_ready=1, memory answering 1 cycle after grant -> first mem_addr=0x100; out_pc sequence 0x100, 0x104, 0x108 with matching instructions, no duplicates.
- out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests issued, occupancy=4, mem_req=0 thereafter; release -> 4 pops in order, then fetching resumes at 0x110.
- Redirect to 0x400 while in WAIT for 0x108, response arriving 2 cycles later -> response for 0x108 discarded, queue empty, next mem_addr=0x400, first out_pc=0x400.
- Redirect in the same cycle as mem_rsp_valid and a dequeue -> neither instruction reaches the output; occupancy=0; next request is 0x400.
- memcnf=1 for 5 cycles while IDLE -> mem_req stays 0, mem_addr stable; memcnf=0 -> request issues the same cycle.
- fetch_pc=0xFFFFFFFC (XLEN=32) -> following address 0x00000000; rst pulsed low mid-WAIT -> all outputs return to reset values immediately, without waiting for clk.
